pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the architectural program counter register and sequences instruction fetch around it.
- Instantiates the combinational program_counter block as its next-PC path.
- Issues one fetch request at a time to instruction memory over a valid/ready handshake, then waits for the response.
- Applies stalls, branch/jump redirects and halt requests from the core; sits between the decode/execute stages and the instruction memory port.

Parameters:
- N, 32, PC and address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- INC, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  blocks issue of a new fetch request.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  N  new PC when redirect_valid=1.
- halt_req  input  1  stop fetching after any outstanding fetch completes.
- fetch_valid  output  1  fetch request valid.
- fetch_addr  output  N  fetch request address (current PC).
- fetch_ready  input  1  instruction memory accepts the request.
- rsp_valid  input  1  instruction data returned for the accepted request.
- inst_valid  output  1  returned instruction is live; 0 means it was killed.
- inst_pc  output  N  PC of the instruction flagged by inst_valid.
- halted  output  1  sequencer in HALTED.
- misaligned_err  output  1  sticky; a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (rst=1 at an edge, in any state, including mid-fetch):
  - PC=RESET_VECTOR, state=IDLE, kill flag cleared.
  - All outputs 0 except fetch_addr=RESET_VECTOR.
  - A response arriving after reset is ignored: inst_valid=0.
- States: IDLE, REQ, WAIT, HALTED.
- IDLE: fetch_valid=0.
  - stall=0 -> REQ next cycle.
  - stall=1 -> remain in IDLE.
- REQ: fetch_valid=1, fetch_addr=PC.
  - Once asserted, fetch_valid holds until fetch_ready.
  - fetch_addr may change only on a redirect.
  - fetch_ready=1 -> WAIT; request accepted at that edge.
- WAIT: fetch_valid=0.
  - On rsp_valid=1: inst_valid=1 for exactly that cycle, unless killed; inst_pc=PC; PC<=PC+INC.
  - Next state is IDLE, or HALTED if a halt is pending.
  - Minimum issue-to-issue latency is 3 cycles (REQ, WAIT with same-cycle response, IDLE).
- Arithmetic: next PC comes from program_counter; PC+INC truncated to N bits. 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Redirect (aligned target):
  - In IDLE: PC<=target.
  - In REQ without fetch_ready: PC<=target; fetch_addr shows target the next cycle; valid stays high.
  - In REQ with fetch_ready in the same cycle: the request is accepted, the kill flag is set, PC<=target.
  - In WAIT: kill flag set, PC<=target.
  - On a killed response: inst_valid=0, PC is not incremented, kill flag cleared.
  - Redirect in HALTED is ignored.
- Redirect (misaligned target): misaligned_err<=1 (cleared only by rst); PC unchanged.
  - Any outstanding fetch is completed and its response killed.
  - Then HALTED.
- halt_req:
  - In IDLE or REQ without fetch_ready: HALTED next cycle; fetch_valid drops.
  - In REQ with fetch_ready, or in WAIT: halt pending; response is delivered normally, then HALTED.
  - HALTED: halted=1, fetch_valid=0, PC frozen; only rst exits.
- Simultaneous halt_req and aligned redirect: redirect updates PC first, then the halt applies. The final PC equals the target.
- Simultaneous stall and redirect in IDLE: PC updates; remain in IDLE.
- stall has no effect in REQ, WAIT or HALTED.
- rsp_valid outside WAIT is ignored.

Decomposition:
- Shared package (philv_pkg): pc_state_t enum {IDLE, REQ, WAIT, HALTED}, PC_RESET_VECTOR, PC_INC, XLEN=32.
- Sub-module: existing program_counter as next-PC path.
- One sequential always block for PC, state, kill and halt-pending.
- One combinational block for outputs and next state.

Test Plan:
- Reset/streaming: rst for 2 cycles, fetch_ready=1, rsp_valid one cycle after accept. Expect fetch_addr 0x0, 0x4, 0x8 every 3 cycles; inst_valid pulses with inst_pc 0x0, 0x4, 0x8.
- Backpressure: fetch_ready=0 for 5 cycles in REQ. Expect fetch_valid stays 1 and fetch_addr stays 0x4; on accept, one inst_valid with inst_pc=0x4.
- Redirect in WAIT: fetch 0x8 accepted, redirect_target=0x100. Expect the 0x8 response has inst_valid=0; next fetch_addr=0x100, then 0x104.
- Misaligned redirect: redirect_target=0x102 in IDLE. Expect misaligned_err=1, halted=1 next cycle, PC stays 0x0; rst clears both.
- Halt mid-fetch: halt_req in WAIT for 0x10. Expect the 0x10 response with inst_valid=1, then halted=1, fetch_valid=0, and redirects ignored.
- Wrap/reset-mid-op: PC=0xFFFF_FFFC fetch completes -> next fetch_addr=0x0. Assert rst in WAIT with rsp_valid the same cycle -> inst_valid=0, state IDLE, PC=RESET_VECTOR.

Source files
------------

// File: rtl/philv_pkg.sv
// Shared definitions for the fetch front end:
// sequencer states, PC reset vector and increment.
package philv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam int PC_INC = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } pc_state_t;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Combinational next-PC path: load a target,
// advance by INC (wrapping at N bits) or hold.
module program_counter
  import philv_pkg::*;
#(
  parameter int N   = XLEN,
  parameter int INC = PC_INC
) (
  input  logic [N-1:0] pc,
  input  logic         load,
  input  logic [N-1:0] target,
  input  logic         advance,
  output logic [N-1:0] next_pc
);

  always_comb begin
    next_pc = pc;
    unique case (1'b1)
      load:    next_pc = target;
      advance: next_pc = pc + N'(INC);
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Owns the architectural PC and runs one fetch at a time
// over a valid/ready port, with stall, redirect and halt.
module pc_sequencer
  import philv_pkg::*;
#(
  parameter int            N            = XLEN,
  parameter logic [N-1:0]  RESET_VECTOR = N'(PC_RESET_VECTOR),
  parameter int            INC          = PC_INC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_target,
  input  logic         halt_req,
  output logic         fetch_valid,
  output logic [N-1:0] fetch_addr,
  input  logic         fetch_ready,
  input  logic         rsp_valid,
  output logic         inst_valid,
  output logic [N-1:0] inst_pc,
  output logic         halted,
  output logic         misaligned_err
);

  pc_state_t    state, state_n;
  logic [N-1:0] pc, pc_n;
  logic         kill, kill_n;
  logic         hpend, hpend_n;
  logic         err, err_n;

  logic         pc_load;
  logic         pc_adv;
  logic         redir_ok;
  logic         redir_bad;
  logic         fv_raw;
  logic         iv_raw;
  logic         dead;
  logic         pend;

  program_counter #(
    .N   (N),
    .INC (INC)
  ) u_next (
    .pc      (pc),
    .load    (pc_load),
    .target  (redirect_target),
    .advance (pc_adv),
    .next_pc (pc_n)
  );

  assign redir_ok  = redirect_valid &&
                     is_aligned(redirect_target[1:0]);
  assign redir_bad = redirect_valid &&
                     !is_aligned(redirect_target[1:0]);

  always_comb begin
    state_n = state;
    kill_n  = kill;
    hpend_n = hpend;
    err_n   = err;
    pc_load = 1'b0;
    pc_adv  = 1'b0;
    fv_raw  = 1'b0;
    iv_raw  = 1'b0;
    dead    = 1'b0;
    pend    = 1'b0;

    if (state != HALTED && redir_bad)
      err_n = 1'b1;

    unique case (state)
      IDLE: begin
        pc_load = redir_ok;
        if (halt_req || redir_bad)
          state_n = HALTED;
        else if (!stall)
          state_n = REQ;
      end
      REQ: begin
        fv_raw  = 1'b1;
        pc_load = redir_ok;
        if (fetch_ready) begin
          state_n = WAIT;
          if (redirect_valid)
            kill_n = 1'b1;
          if (halt_req || redir_bad)
            hpend_n = 1'b1;
        end else if (halt_req || redir_bad) begin
          state_n = HALTED;
        end
      end
      WAIT: begin
        // A redirect alongside the response kills it too.
        dead    = kill || redirect_valid;
        pend    = hpend || halt_req || redir_bad;
        pc_load = redir_ok;
        if (redirect_valid)
          kill_n = 1'b1;
        if (pend)
          hpend_n = 1'b1;
        if (rsp_valid) begin
          iv_raw  = !dead;
          pc_adv  = !dead;
          kill_n  = 1'b0;
          hpend_n = 1'b0;
          state_n = pend ? HALTED : IDLE;
        end
      end
      HALTED: begin
        state_n = HALTED;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_VECTOR;
      kill  <= 1'b0;
      hpend <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      kill  <= kill_n;
      hpend <= hpend_n;
      err   <= err_n;
    end
  end

  // Reset masks outputs in the cycle it is asserted.
  assign fetch_valid    = fv_raw && !rst;
  assign fetch_addr     = rst ? RESET_VECTOR : pc;
  assign inst_valid     = iv_raw && !rst;
  assign inst_pc        = inst_valid ? pc : '0;
  assign halted         = (state == HALTED) && !rst;
  assign misaligned_err = err && !rst;

endmodule
